// File: rtl/mac_accumulator_pkg.sv
// mac_pkg: shared FSM encoding and width constants for the MAC accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mac_pkg;

  // Frame FSM: collecting the first beat, collecting further beats, presenting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Default operand widths of the multiplier feeding the accumulator
  localparam int DEF_A_WIDTH    = 8;
  localparam int DEF_B_WIDTH    = 8;
  localparam int DEF_CNT_WIDTH  = 8;

  // Headroom bits above the product width; the accumulator must be strictly wider
  localparam int ACC_GUARD_BITS = 8;
  localparam int MIN_ACC_MARGIN = 1;

  function automatic bit acc_width_ok(input int acc_width, input int prod_width);
    return (acc_width - prod_width) >= MIN_ACC_MARGIN;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product input stream and frame result output of the accumulator.
// Latency: n/a (wiring only).
// Backpressure: prod_ready from the accumulator, acc_ready from the result consumer.
interface mac_accumulator_if #(
  parameter int PRODUCT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int CNT_WIDTH     = 8
);

  logic                     prod_valid;
  logic                     prod_ready;
  logic [PRODUCT_WIDTH-1:0] product;
  logic                     prod_last;
  logic                     tc;

  logic                     acc_valid;
  logic                     acc_ready;
  logic [ACC_WIDTH-1:0]     acc_data;
  logic [CNT_WIDTH-1:0]     acc_cnt;
  logic                     acc_ovf;

  // Environment side: sources products, sinks results
  modport master (
    output prod_valid, product, prod_last, tc, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_cnt, acc_ovf
  );

  // Accumulator side: sinks products, sources results
  modport slave (
    input  prod_valid, product, prod_last, tc, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_cnt, acc_ovf
  );

endinterface

// File: rtl/mac_accumulator_acc_sat_adder.sv
// acc_sat_adder: adds an extended product to the running sum; SATURATE_EN adds clamp + overflow.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
module acc_sat_adder
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] sum,
  input  logic [ACC_WIDTH-1:0] addend,
  input  logic                 tc,
  output logic [ACC_WIDTH-1:0] sum_nxt,
  output logic                 ovf
);

  localparam int MSB = ACC_WIDTH - 1;

`ifdef SATURATE_EN
  logic [ACC_WIDTH:0] raw;
  logic               ovf_s;
  logic               ovf_u;

  // Overflow is carry-out for unsigned frames and a sign flip of like-signed operands for
  // signed frames; on overflow the result pins to the nearest representable extreme.
  always_comb begin
    raw     = {1'b0, sum} + {1'b0, addend};
    ovf_u   = raw[ACC_WIDTH];
    ovf_s   = (sum[MSB] == addend[MSB]) && (raw[MSB] != sum[MSB]);
    ovf     = tc ? ovf_s : ovf_u;
    sum_nxt = raw[ACC_WIDTH-1:0];
    if (ovf) begin
      if (!tc) begin
        sum_nxt = '1;
      end else if (sum[MSB]) begin
        sum_nxt = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        sum_nxt = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end
`else
  // Wrapping add: signedness does not change the modulo result
  logic unused_tc;
  assign unused_tc = tc;

  // Plain modulo-2^ACC_WIDTH sum, overflow never reported
  always_comb begin
    sum_nxt = sum + addend;
    ovf     = 1'b0;
  end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates a prod_last-terminated frame of products; SATURATE_EN selects clamping.
// Latency: acc_valid rises the cycle after the prod_last beat is accepted.
// Backpressure: result held with prod_ready=0 until acc_ready; new frame starts the cycle after.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int A_WIDTH       = DEF_A_WIDTH,
  parameter int B_WIDTH       = DEF_B_WIDTH,
  parameter int PRODUCT_WIDTH = A_WIDTH + B_WIDTH,
  parameter int ACC_WIDTH     = PRODUCT_WIDTH + ACC_GUARD_BITS,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  mac_accumulator_if.slave bus
);

  localparam int EXT_BITS = ACC_WIDTH - PRODUCT_WIDTH;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   sum;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   tc_q;
  logic                   acc_valid_q;
  logic                   prod_ready_q;

  logic                   fire;
  logic                   tc_eff;
  logic [ACC_WIDTH-1:0]   ext_prod;
  logic [ACC_WIDTH-1:0]   add_base;
  logic [ACC_WIDTH-1:0]   sum_nxt;
  logic                   ovf_nxt;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  assign fire = bus.prod_valid && prod_ready_q;

  // First beat of a frame uses the live tc and starts from zero; later beats use the latched mode
  always_comb begin
    tc_eff   = (state == IDLE) ? bus.tc : tc_q;
    add_base = (state == IDLE) ? '0 : sum;
    if (tc_eff) begin
      ext_prod = {{EXT_BITS{bus.product[PRODUCT_WIDTH-1]}}, bus.product};
    end else begin
      ext_prod = {{EXT_BITS{1'b0}}, bus.product};
    end
    cnt_inc = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
  end

  acc_sat_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_adder (
    .sum     (add_base),
    .addend  (ext_prod),
    .tc      (tc_eff),
    .sum_nxt (sum_nxt),
    .ovf     (ovf_nxt)
  );

`ifdef SATURATE_EN
  logic ovf_q;
  assign bus.acc_ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf  = ovf_nxt;
  assign bus.acc_ovf = 1'b0;
`endif

  // Frame FSM with the sum, beat counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sum          <= '0;
      cnt          <= '0;
      tc_q         <= 1'b0;
      acc_valid_q  <= 1'b0;
      prod_ready_q <= 1'b1;
`ifdef SATURATE_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            sum  <= sum_nxt;
            cnt  <= CNT_WIDTH'(1);
            tc_q <= bus.tc;
`ifdef SATURATE_EN
            ovf_q <= ovf_nxt;
`endif
            if (bus.prod_last) begin
              state        <= HOLD;
              acc_valid_q  <= 1'b1;
              prod_ready_q <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (fire) begin
            sum <= sum_nxt;
            cnt <= cnt_inc;
`ifdef SATURATE_EN
            ovf_q <= ovf_q | ovf_nxt;
`endif
            if (bus.prod_last) begin
              state        <= HOLD;
              acc_valid_q  <= 1'b1;
              prod_ready_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state        <= IDLE;
            acc_valid_q  <= 1'b0;
            prod_ready_q <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          acc_valid_q  <= 1'b0;
          prod_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.acc_data   = sum;
  assign bus.acc_cnt    = cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: drives product frames into 24-bit and 17-bit accumulators in lockstep.
// Latency: checks acc_valid one cycle after the last beat and release one cycle after acc_ready.
// Backpressure: holds acc_ready low in HOLD with pending products and checks stability.
module tb_mac_accumulator;
  import mac_pkg::*;

  localparam int PW   = 16;
  localparam int AW   = 24;
  localparam int AW17 = 17;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_accumulator_if #(.PRODUCT_WIDTH(PW), .ACC_WIDTH(AW),   .CNT_WIDTH(CW)) bus ();
  mac_accumulator_if #(.PRODUCT_WIDTH(PW), .ACC_WIDTH(AW17), .CNT_WIDTH(CW)) bus17 ();

  assign bus17.prod_valid = bus.prod_valid;
  assign bus17.product    = bus.product;
  assign bus17.prod_last  = bus.prod_last;
  assign bus17.tc         = bus.tc;
  assign bus17.acc_ready  = bus.acc_ready;

  mac_accumulator #(.A_WIDTH(8), .B_WIDTH(8), .PRODUCT_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mac_accumulator #(.A_WIDTH(8), .B_WIDTH(8), .PRODUCT_WIDTH(PW), .ACC_WIDTH(AW17), .CNT_WIDTH(CW))
    u_dut17 (.clk(clk), .rst_n(rst_n), .bus(bus17));

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] prods[$];
  bit          tcs[$];

  logic [AW-1:0]   last_data;
  logic [CW-1:0]   last_cnt;
  logic            last_ovf;
  logic [AW17-1:0] last_data17;
  logic            last_ovf17;

  // Reference: frame sum in plain integer arithmetic at width w, mode from the first beat
  function automatic void model(input int w, output longint exp_sum, output bit exp_ovf);
    longint u, t, s, v, maxu, smax, smin;
    maxu = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    u = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < prods.size(); i++) begin
      v = longint'(prods[i]);
      if (tcs[0]) begin
        if (v >= 32768) v = v - 65536;
        s = (u > smax) ? u - (maxu + 1) : u;
        t = s + v;
        if (t > smax || t < smin) begin
          exp_ovf = 1'b1;
`ifdef SATURATE_EN
          t = (t > smax) ? smax : smin;
`endif
        end
      end else begin
        t = u + v;
        if (t > maxu) begin
          exp_ovf = 1'b1;
`ifdef SATURATE_EN
          t = maxu;
`endif
        end
      end
      u = t & maxu;
    end
    exp_sum = u;
`ifndef SATURATE_EN
    exp_ovf = 1'b0;
`endif
  endfunction

  task automatic send_beat(input logic [15:0] p, input bit last, input bit tcv, output bit ok);
    bus.prod_valid = 1'b1;
    bus.product    = p;
    bus.prod_last  = last;
    bus.tc         = tcv;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = (bus.prod_ready === 1'b1);
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;
    bus.product    = 16'($urandom);
    bus.prod_last  = 1'($urandom);
    bus.tc         = 1'($urandom);
  endtask

  task automatic run_frame(input int hold, input bit gaps);
    longint e24, e17;
    bit     o24, o17, ok;
    int     n, ecnt;
    n = prods.size();
    model(AW, e24, o24);
    model(AW17, e17, o17);
    ecnt = (n > 255) ? 255 : n;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.acc_ready = 1'($urandom);
          @(negedge clk);
        end
      end
      bus.acc_ready = (i < n - 1) ? 1'($urandom) : 1'b0;
      n_vec++;
      if (bus.acc_valid !== 1'b0) begin
        n_err++;
        $display("FAIL early_valid: acc_valid=%b required 0 before beat %0d", bus.acc_valid, i);
      end
      send_beat(prods[i], i == n - 1, tcs[i], ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL beat_accept: beat %0d not accepted within 50 cycles, required accept", i);
      end
    end
    last_data   = bus.acc_data;
    last_cnt    = bus.acc_cnt;
    last_ovf    = bus.acc_ovf;
    last_data17 = bus17.acc_data;
    last_ovf17  = bus17.acc_ovf;
    n_vec += 8;
    if (bus.acc_valid !== 1'b1) begin
      n_err++; $display("FAIL valid_latency: acc_valid=%b required 1", bus.acc_valid);
    end
    if (bus.acc_data !== e24[AW-1:0]) begin
      n_err++; $display("FAIL data24: got %h required %h", bus.acc_data, e24[AW-1:0]);
    end
    if (bus.acc_cnt !== CW'(ecnt)) begin
      n_err++; $display("FAIL cnt: got %0d required %0d", bus.acc_cnt, ecnt);
    end
    if (bus.acc_ovf !== o24) begin
      n_err++; $display("FAIL ovf24: got %b required %b", bus.acc_ovf, o24);
    end
    if (bus17.acc_valid !== 1'b1) begin
      n_err++; $display("FAIL valid17: acc_valid=%b required 1", bus17.acc_valid);
    end
    if (bus17.acc_data !== e17[AW17-1:0]) begin
      n_err++; $display("FAIL data17: got %h required %h", bus17.acc_data, e17[AW17-1:0]);
    end
    if (bus17.acc_ovf !== o17) begin
      n_err++; $display("FAIL ovf17: got %b required %b", bus17.acc_ovf, o17);
    end
    if (bus.prod_ready !== 1'b0) begin
      n_err++; $display("FAIL hold_ready: prod_ready=%b required 0", bus.prod_ready);
    end
    for (int h = 0; h < hold; h++) begin
      bus.prod_valid = 1'($urandom);
      bus.product    = 16'($urandom);
      bus.prod_last  = 1'b1;
      @(negedge clk);
      n_vec += 4;
      if (bus.acc_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_valid: cycle %0d acc_valid=%b required 1", h, bus.acc_valid);
      end
      if (bus.acc_data !== e24[AW-1:0]) begin
        n_err++; $display("FAIL hold_data: cycle %0d got %h required %h", h, bus.acc_data, e24[AW-1:0]);
      end
      if (bus.acc_cnt !== CW'(ecnt)) begin
        n_err++; $display("FAIL hold_cnt: cycle %0d got %0d required %0d", h, bus.acc_cnt, ecnt);
      end
      if (bus.prod_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_prod_ready: cycle %0d got %b required 0", h, bus.prod_ready);
      end
    end
    bus.acc_ready = 1'b1;
    @(negedge clk);
    bus.prod_valid = 1'b0;
    bus.acc_ready  = 1'b0;
    n_vec += 2;
    if (bus.acc_valid !== 1'b0) begin
      n_err++; $display("FAIL release_valid: acc_valid=%b required 0", bus.acc_valid);
    end
    if (bus.prod_ready !== 1'b1) begin
      n_err++; $display("FAIL release_ready: prod_ready=%b required 1", bus.prod_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec += 5;
    if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b required 0", bus.acc_valid); end
    if (bus.acc_data !== '0) begin n_err++; $display("FAIL rst_data: got %h required 0", bus.acc_data); end
    if (bus.acc_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d required 0", bus.acc_cnt); end
    if (bus.acc_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b required 0", bus.acc_ovf); end
    if (bus.prod_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", bus.prod_ready); end
  endtask

  task automatic test_unsigned();
    prods = '{16'h0010, 16'h0020, 16'h0030};
    tcs   = '{1'b0, 1'b0, 1'b0};
    run_frame(0, 1'b0);
    n_vec += 2;
    if (last_data !== 24'h000060) begin n_err++; $display("FAIL unsigned_data: got %h required 000060", last_data); end
    if (last_cnt !== 8'd3) begin n_err++; $display("FAIL unsigned_cnt: got %0d required 3", last_cnt); end
  endtask

  task automatic test_signed();
    prods = '{16'hFFF6, 16'h0005};
    tcs   = '{1'b1, 1'b1};
    run_frame(0, 1'b0);
    n_vec += 2;
    if (last_data !== 24'hFFFFFB) begin n_err++; $display("FAIL signed_data: got %h required FFFFFB", last_data); end
    if (last_cnt !== 8'd2) begin n_err++; $display("FAIL signed_cnt: got %0d required 2", last_cnt); end
  endtask

  task automatic test_backpressure();
    prods = '{16'h0011, 16'h0022, 16'h0033};
    tcs   = '{1'b0, 1'b1, 1'b0};
    run_frame(5, 1'b0);
  endtask

  task automatic test_overflow17();
    prods = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    tcs   = '{1'b0, 1'b0, 1'b0};
    run_frame(1, 1'b0);
    n_vec += 2;
`ifdef SATURATE_EN
    if (last_data17 !== 17'h1FFFF) begin n_err++; $display("FAIL ovf17_data: got %h required 1FFFF", last_data17); end
    if (last_ovf17 !== 1'b1) begin n_err++; $display("FAIL ovf17_flag: got %b required 1", last_ovf17); end
`else
    if (last_data17 !== 17'h0FFFD) begin n_err++; $display("FAIL ovf17_data: got %h required 0FFFD", last_data17); end
    if (last_ovf17 !== 1'b0) begin n_err++; $display("FAIL ovf17_flag: got %b required 0", last_ovf17); end
`endif
  endtask

  task automatic test_tc_latch();
    prods = '{16'hFFFF, 16'hFFFF};
    tcs   = '{1'b1, 1'b0};
    run_frame(0, 1'b0);
    n_vec++;
    if (last_data !== 24'hFFFFFE) begin n_err++; $display("FAIL tc_latch_data: got %h required FFFFFE", last_data); end
    prods = '{16'h0007};
    tcs   = '{1'b0};
    run_frame(0, 1'b0);
    n_vec += 2;
    if (last_data !== 24'h000007) begin n_err++; $display("FAIL single_data: got %h required 000007", last_data); end
    if (last_cnt !== 8'd1) begin n_err++; $display("FAIL single_cnt: got %0d required 1", last_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    send_beat(16'h0005, 1'b0, 1'b0, ok);
    send_beat(16'h0006, 1'b0, 1'b0, ok);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec += 5;
    if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b required 0", bus.acc_valid); end
    if (bus.acc_data !== '0) begin n_err++; $display("FAIL midrst_data: got %h required 0", bus.acc_data); end
    if (bus.acc_cnt !== '0) begin n_err++; $display("FAIL midrst_cnt: got %0d required 0", bus.acc_cnt); end
    if (bus.acc_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b required 0", bus.acc_ovf); end
    if (bus.prod_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b required 1", bus.prod_ready); end
    @(negedge clk);
    n_vec++;
    if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL midrst_novalid: got %b required 0", bus.acc_valid); end
    prods = '{16'h0002};
    tcs   = '{1'b0};
    run_frame(0, 1'b0);
    n_vec++;
    if (last_data !== 24'h000002) begin n_err++; $display("FAIL midrst_next: got %h required 000002", last_data); end
  endtask

  task automatic test_cnt_saturate();
    prods.delete();
    tcs.delete();
    for (int i = 0; i < 260; i++) begin
      prods.push_back(16'h0001);
      tcs.push_back(1'b0);
    end
    run_frame(0, 1'b0);
    n_vec += 2;
    if (last_cnt !== 8'hFF) begin n_err++; $display("FAIL cnt_sat: got %0d required 255", last_cnt); end
    if (last_data !== 24'd260) begin n_err++; $display("FAIL cnt_sat_data: got %0d required 260", last_data); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 6);
      prods.delete();
      tcs.delete();
      for (int i = 0; i < n; i++) begin
        prods.push_back(16'($urandom));
        tcs.push_back(1'($urandom));
      end
      run_frame($urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 3);
      prods.delete();
      tcs.delete();
      for (int i = 0; i < n; i++) begin
        prods.push_back(16'($urandom_range(0, 255)) | ((f % 2) != 0 ? 16'hFF00 : 16'h0000));
        tcs.push_back(1'(f % 2));
      end
      run_frame(0, 1'b0);
    end
  endtask

  initial begin
    bus.prod_valid = 1'b0;
    bus.product    = '0;
    bus.prod_last  = 1'b0;
    bus.tc         = 1'b0;
    bus.acc_ready  = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_overflow17();
    test_tc_latch();
    test_reset_mid_frame();
    test_cnt_saturate();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
